// File: rtl/instruction_fetch_unit_if.sv
// rtl/instruction_fetch_unit_if.sv - fetch-unit bus: pipeline control, program-load port and IF/ID outputs
// fetch_count is present only when IFU_FETCH_COUNT_EN is defined.
interface instruction_fetch_unit_if #(
  parameter int IMEM_DEPTH = 16
);
  localparam int AW = $clog2(IMEM_DEPTH);

  logic          stall;
  logic          branch_taken;
  logic [63:0]   branch_target;
  logic          imem_wr_en;
  logic [AW-1:0] imem_wr_addr;
  logic [31:0]   imem_wr_data;
  logic [63:0]   pc_out;
  logic [31:0]   instruction;
  logic [6:0]    Opcode;
  logic [3:0]    Funct;
  logic          valid;
`ifdef IFU_FETCH_COUNT_EN
  logic [31:0]   fetch_count;
`endif

  modport master (
`ifdef IFU_FETCH_COUNT_EN
    input  fetch_count,
`endif
    output stall, branch_taken, branch_target,
    output imem_wr_en, imem_wr_addr, imem_wr_data,
    input  pc_out, instruction, Opcode, Funct, valid
  );

  modport slave (
`ifdef IFU_FETCH_COUNT_EN
    output fetch_count,
`endif
    input  stall, branch_taken, branch_target,
    input  imem_wr_en, imem_wr_addr, imem_wr_data,
    output pc_out, instruction, Opcode, Funct, valid
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC, instruction memory and IF/ID register with flush/stall
// Define IFU_FETCH_COUNT_EN to add the 32-bit fetch_count output.
module instruction_fetch_unit #(
  parameter int          IMEM_DEPTH = 16,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic                    clk,
  input  logic                    reset_n,
  instruction_fetch_unit_if.slave bus
);
  localparam int AW = $clog2(IMEM_DEPTH);

  logic [31:0]   imem [IMEM_DEPTH];
  logic [63:0]   pc;
  logic [63:0]   pc_out_q;
  logic [31:0]   instr_q;
  logic          valid_q;
  logic [AW-1:0] fetch_idx;
  logic [63:0]   redirect_pc;
  logic          do_fetch;

  assign fetch_idx   = pc[AW+1:2];
  assign redirect_pc = bus.branch_target & ~64'h3;
  assign do_fetch    = !bus.branch_taken && !bus.stall;

  // Program-load port: not reset and independent of pipeline control.
  always_ff @(posedge clk) begin
    if (bus.imem_wr_en)
      imem[bus.imem_wr_addr] <= bus.imem_wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc       <= 64'd0;
      pc_out_q <= 64'd0;
      instr_q  <= NOP_INSTR;
      valid_q  <= 1'b0;
    end else if (bus.branch_taken) begin
      pc       <= redirect_pc;
      pc_out_q <= 64'd0;
      instr_q  <= NOP_INSTR;
      valid_q  <= 1'b0;
    end else if (!bus.stall) begin
      pc       <= pc + 64'd4;
      pc_out_q <= pc;
      instr_q  <= imem[fetch_idx];
      valid_q  <= 1'b1;
    end
  end

`ifdef IFU_FETCH_COUNT_EN
  logic [31:0] fetch_count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      fetch_count_q <= 32'd0;
    else if (do_fetch)
      fetch_count_q <= fetch_count_q + 32'd1;
  end

  assign bus.fetch_count = fetch_count_q;
`else
  logic unused_do_fetch;
  assign unused_do_fetch = do_fetch;
`endif

  assign bus.pc_out      = pc_out_q;
  assign bus.instruction = instr_q;
  assign bus.valid       = valid_q;
  assign bus.Opcode      = instr_q[6:0];
  assign bus.Funct       = {instr_q[30], instr_q[14:12]};
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;
  logic clk;
  logic reset_n;
  int   tests;
  int   fails;
  logic [31:0] image [16];

  instruction_fetch_unit_if #(.IMEM_DEPTH(16)) ifc ();

  instruction_fetch_unit #(.IMEM_DEPTH(16), .NOP_INSTR(32'h0000_0013)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(ifc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    tests++; if (ifc.pc_out !== 64'd0) begin fails++; $display("FAIL reset_pc_out got %h exp 0", ifc.pc_out); end
    tests++; if (ifc.instruction !== 32'h0000_0013) begin fails++; $display("FAIL reset_instr got %h exp 00000013", ifc.instruction); end
    tests++; if (ifc.valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", ifc.valid); end
    tests++; if (ifc.Opcode !== 7'b0010011) begin fails++; $display("FAIL reset_opcode got %b exp 0010011", ifc.Opcode); end
    tests++; if (ifc.Funct !== 4'b0000) begin fails++; $display("FAIL reset_funct got %b exp 0000", ifc.Funct); end
  endtask

  task automatic load_program();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      ifc.imem_wr_en   = 1'b1;
      ifc.imem_wr_addr = 4'(i);
      ifc.imem_wr_data = image[i];
    end
    @(negedge clk);
    ifc.imem_wr_en = 1'b0;
  endtask

  task automatic test_basic_fetch();
    logic [6:0] exp_op [4];
    exp_op[0] = 7'b0010011; exp_op[1] = 7'b0110011;
    exp_op[2] = 7'b0000011; exp_op[3] = 7'b0100011;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++; if (ifc.pc_out !== 64'(4 * i)) begin fails++; $display("FAIL basic_pc[%0d] got %h exp %h", i, ifc.pc_out, 64'(4 * i)); end
      tests++; if (ifc.instruction !== image[i]) begin fails++; $display("FAIL basic_instr[%0d] got %h exp %h", i, ifc.instruction, image[i]); end
      tests++; if (ifc.Opcode !== exp_op[i]) begin fails++; $display("FAIL basic_opcode[%0d] got %b exp %b", i, ifc.Opcode, exp_op[i]); end
      tests++; if (ifc.valid !== 1'b1) begin fails++; $display("FAIL basic_valid[%0d] got %b exp 1", i, ifc.valid); end
    end
  endtask

  task automatic test_reset_pulse();
    #1 reset_n = 1'b0;
    #1;
    tests++; if (ifc.pc_out !== 64'd0) begin fails++; $display("FAIL pulse_pc got %h exp 0", ifc.pc_out); end
    tests++; if (ifc.valid !== 1'b0) begin fails++; $display("FAIL pulse_valid got %b exp 0", ifc.valid); end
    tests++; if (ifc.instruction !== 32'h0000_0013) begin fails++; $display("FAIL pulse_instr got %h exp 00000013", ifc.instruction); end
    #1 reset_n = 1'b1;
    tick();
    tests++; if (ifc.pc_out !== 64'd0) begin fails++; $display("FAIL pulse_restart_pc got %h exp 0", ifc.pc_out); end
    tests++; if (ifc.instruction !== image[0]) begin fails++; $display("FAIL pulse_mem_intact got %h exp %h", ifc.instruction, image[0]); end
    tests++; if (ifc.valid !== 1'b1) begin fails++; $display("FAIL pulse_restart_valid got %b exp 1", ifc.valid); end
  endtask

  task automatic test_stall();
    tick();
    tests++; if (ifc.pc_out !== 64'd4) begin fails++; $display("FAIL stall_pre_pc got %h exp 4", ifc.pc_out); end
    ifc.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (ifc.pc_out !== 64'd4) begin fails++; $display("FAIL stall_hold_pc[%0d] got %h exp 4", i, ifc.pc_out); end
      tests++; if (ifc.instruction !== image[1]) begin fails++; $display("FAIL stall_hold_instr[%0d] got %h exp %h", i, ifc.instruction, image[1]); end
      tests++; if (ifc.valid !== 1'b1) begin fails++; $display("FAIL stall_hold_valid[%0d] got %b exp 1", i, ifc.valid); end
    end
    ifc.stall = 1'b0;
    tick();
    tests++; if (ifc.pc_out !== 64'd8) begin fails++; $display("FAIL stall_resume_pc got %h exp 8", ifc.pc_out); end
    tests++; if (ifc.instruction !== image[2]) begin fails++; $display("FAIL stall_resume_instr got %h exp %h", ifc.instruction, image[2]); end
  endtask

  task automatic test_sub_funct();
    tick();
    tick();
    tests++; if (ifc.pc_out !== 64'd16) begin fails++; $display("FAIL sub_pc got %h exp 10", ifc.pc_out); end
    tests++; if (ifc.instruction !== 32'h40B5_0533) begin fails++; $display("FAIL sub_instr got %h exp 40b50533", ifc.instruction); end
    tests++; if (ifc.Funct !== 4'b1000) begin fails++; $display("FAIL sub_funct got %b exp 1000", ifc.Funct); end
    tests++; if (ifc.Opcode !== 7'b0110011) begin fails++; $display("FAIL sub_opcode got %b exp 0110011", ifc.Opcode); end
  endtask

  task automatic test_branch_priority();
    ifc.branch_taken  = 1'b1;
    ifc.stall         = 1'b1;
    ifc.branch_target = 64'h26;
    tick();
    ifc.branch_taken = 1'b0;
    ifc.stall        = 1'b0;
    tests++; if (ifc.valid !== 1'b0) begin fails++; $display("FAIL flush_valid got %b exp 0", ifc.valid); end
    tests++; if (ifc.instruction !== 32'h0000_0013) begin fails++; $display("FAIL flush_instr got %h exp 00000013", ifc.instruction); end
    tests++; if (ifc.pc_out !== 64'd0) begin fails++; $display("FAIL flush_pc got %h exp 0", ifc.pc_out); end
    tests++; if (ifc.Opcode !== 7'b0010011 || ifc.Funct !== 4'b0000) begin fails++; $display("FAIL flush_decode got %b/%b exp 0010011/0000", ifc.Opcode, ifc.Funct); end
    tick();
    tests++; if (ifc.pc_out !== 64'h24) begin fails++; $display("FAIL branch_pc got %h exp 24", ifc.pc_out); end
    tests++; if (ifc.instruction !== image[9]) begin fails++; $display("FAIL branch_instr got %h exp %h", ifc.instruction, image[9]); end
    tests++; if (ifc.valid !== 1'b1) begin fails++; $display("FAIL branch_valid got %b exp 1", ifc.valid); end
  endtask

  task automatic test_pc_wrap();
    ifc.branch_taken  = 1'b1;
    ifc.branch_target = 64'hFFFF_FFFF_FFFF_FFFE;
    tick();
    ifc.branch_taken = 1'b0;
    tick();
    tests++; if (ifc.pc_out !== 64'hFFFF_FFFF_FFFF_FFFC) begin fails++; $display("FAIL wrap_top_pc got %h exp fffffffffffffffc", ifc.pc_out); end
    tests++; if (ifc.instruction !== image[15]) begin fails++; $display("FAIL wrap_top_instr got %h exp %h", ifc.instruction, image[15]); end
    tick();
    tests++; if (ifc.pc_out !== 64'd0) begin fails++; $display("FAIL wrap_zero_pc got %h exp 0", ifc.pc_out); end
    tests++; if (ifc.instruction !== image[0]) begin fails++; $display("FAIL wrap_zero_instr got %h exp %h", ifc.instruction, image[0]); end
  endtask

  task automatic test_same_edge_write();
    logic [31:0] old_word;
    old_word = image[1];
    ifc.imem_wr_en   = 1'b1;
    ifc.imem_wr_addr = 4'd1;
    ifc.imem_wr_data = 32'hCAFE_0537;
    tick();
    ifc.imem_wr_en = 1'b0;
    image[1] = 32'hCAFE_0537;
    tests++; if (ifc.pc_out !== 64'd4) begin fails++; $display("FAIL wr_fetch_pc got %h exp 4", ifc.pc_out); end
    tests++; if (ifc.instruction !== old_word) begin fails++; $display("FAIL wr_fetch_old got %h exp %h", ifc.instruction, old_word); end
    ifc.branch_taken  = 1'b1;
    ifc.branch_target = 64'd4;
    tick();
    ifc.branch_taken = 1'b0;
    tick();
    tests++; if (ifc.instruction !== 32'hCAFE_0537) begin fails++; $display("FAIL wr_fetch_new got %h exp cafe0537", ifc.instruction); end
  endtask

`ifdef IFU_FETCH_COUNT_EN
  task automatic test_fetch_count();
    reset_n = 1'b0;
    #1;
    tests++; if (ifc.fetch_count !== 32'd0) begin fails++; $display("FAIL count_reset got %0d exp 0", ifc.fetch_count); end
    #1 reset_n = 1'b1;
    repeat (10) tick();
    ifc.branch_taken  = 1'b1;
    ifc.branch_target = 64'd0;
    tick();
    ifc.branch_taken = 1'b0;
    ifc.stall        = 1'b1;
    repeat (2) tick();
    ifc.stall = 1'b0;
    tests++; if (ifc.fetch_count !== 32'd10) begin fails++; $display("FAIL count_total got %0d exp 10", ifc.fetch_count); end
  endtask
`endif

  initial begin
    tests = 0;
    fails = 0;
    image[0] = 32'h00A0_0093;
    image[1] = 32'h00B5_0533;
    image[2] = 32'h0005_B503;
    image[3] = 32'h00B5_3023;
    image[4] = 32'h40B5_0533;
    for (int i = 5; i < 16; i++) image[i] = 32'h0000_0013 | (32'(i) << 7);
    reset_n           = 1'b1;
    ifc.stall         = 1'b0;
    ifc.branch_taken  = 1'b0;
    ifc.branch_target = 64'd0;
    ifc.imem_wr_en    = 1'b0;
    ifc.imem_wr_addr  = 4'd0;
    ifc.imem_wr_data  = 32'd0;

    test_reset();
    load_program();
    test_basic_fetch();
    test_reset_pulse();
    test_stall();
    test_sub_funct();
    test_branch_priority();
    test_pc_wrap();
    test_same_edge_write();
`ifdef IFU_FETCH_COUNT_EN
    test_fetch_count();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameter IMEM_DEPTH, 16, number of 32-bit instruction memory words (power of two, 4..256).
REQ-002 SHALL have parameter NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0).
REQ-003 SHALL have port clk  input  1  single clock, all state rising-edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port stall  input  1  hold PC and IF/ID register.
REQ-006 SHALL have port branch_taken  input  1  redirect from downstream (Branch & Zero).
REQ-007 SHALL have port branch_target  input  64  redirect byte address.
REQ-008 SHALL have port imem_wr_en  input  1  program-load write strobe.
REQ-009 SHALL have port imem_wr_addr  input  log2(IMEM_DEPTH)  word index for load.
REQ-010 SHALL have port imem_wr_data  input  32  word to load.
REQ-011 SHALL have port pc_out  output  64  PC of instruction held in IF/ID.
REQ-012 SHALL have port instruction  output  32  IF/ID instruction register.
REQ-013 SHALL have port Opcode  output  7  instruction[6:0], feeds top_control.
REQ-014 SHALL have port Funct  output  4  {instruction[30], instruction[14:12]}, feeds top_control.
REQ-015 SHALL have port valid  output  1  IF/ID holds a real fetched instruction.

Function
REQ-016 SHALL keep internal 64-bit PC register; fetch word index = PC[log2(IMEM_DEPTH)+1:2] (wraps modulo IMEM_DEPTH).
REQ-017 SHALL read instruction memory combinationally; write synchronously when imem_wr_en=1.
REQ-018 Same-edge write and fetch of one index SHALL capture old data into IF/ID; new data visible next fetch.
REQ-019 Normal cycle (stall=0, branch_taken=0): IF/ID <= {PC, imem[idx]}, valid<=1, PC<=PC+4.
REQ-020 branch_taken=1 SHALL have priority over stall: PC<=branch_target with bits[1:0] forced 0; instruction<=NOP_INSTR, valid<=0, pc_out<=0.
REQ-021 stall=1, branch_taken=0: PC, pc_out, instruction, valid SHALL hold.
REQ-022 Fetch latency SHALL be one cycle: first valid=1 on the first rising edge after reset_n release.
REQ-023 PC SHALL wrap 64'hFFFF_FFFF_FFFF_FFFC -> 0 without error.
REQ-024 Opcode and Funct SHALL be purely combinational from instruction register (NOP -> Opcode 0010011, Funct 0000).
REQ-025 Memory writes SHALL be accepted regardless of stall, branch_taken or reset_n state.

Reset
REQ-026 reset_n=0 SHALL immediately set PC=0, pc_out=0, instruction=NOP_INSTR, valid=0 (and fetch_count=0 when present).
REQ-027 Instruction memory contents SHALL NOT be cleared by reset.
REQ-028 Reset asserted mid-stream SHALL discard IF/ID contents; fetch restarts at address 0 after release.

Configuration
REQ-029 Macro IFU_FETCH_COUNT_EN defined SHALL add output fetch_count (32 bits), incremented by 1 on each cycle where valid is loaded with 1, wrapping at 2^32.
REQ-030 Macro IFU_FETCH_COUNT_EN undefined SHALL omit fetch_count port and counter logic; all other behaviour identical.

Verification
REQ-031 Load imem[0..3]=0x00A00093,0x00B50533,0x0005B503,0x00B53023; release reset -> pc_out 0,4,8,12 on consecutive edges; Opcode 0010011,0110011,0000011,0100011; valid=1.
REQ-032 Word 0x40B50533 (sub) fetched -> Funct=1000, Opcode=0110011.
REQ-033 stall=1 for 3 cycles at pc_out=4 -> pc_out, instruction held 3 cycles, then pc_out=8.
REQ-034 branch_taken=1, stall=1, branch_target=0x26 same cycle -> next edge valid=0, instruction=0x00000013; following edge pc_out=0x24, idx 9.
REQ-035 reset_n pulsed low between edges at pc_out=12 -> outputs reset without clock edge; after release pc_out=0; memory intact.
REQ-036 With IFU_FETCH_COUNT_EN: 10 normal fetches, 1 flush, 2 stalls -> fetch_count=10.
